// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the MIPS execute stage.
//   - ALU operation codes, also used by the ALU control decoder upstream.
//   - FSM state encoding for alu_exec_stage.
package alu_pkg;

  localparam logic [3:0] ALU_AND    = 4'd0;
  localparam logic [3:0] ALU_OR     = 4'd1;
  localparam logic [3:0] ALU_ADD    = 4'd2;
  localparam logic [3:0] ALU_PASS_A = 4'd3;  // jr: forward rs unchanged
  localparam logic [3:0] ALU_SLL    = 4'd4;
  localparam logic [3:0] ALU_SRL    = 4'd5;
  localparam logic [3:0] ALU_SUB    = 4'd6;
  localparam logic [3:0] ALU_SLT    = 4'd7;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/alu_comb.sv
// alu_comb: purely combinational datapath for the single-cycle ALU ops.
//   Ports:
//     alu_ctl  in  4      operation code (alu_pkg ALU_* codes)
//     a, b     in  WIDTH  operands
//     result   out WIDTH  AND/OR/ADD/SUB/SLT/PASS_A result; SLL/SRL return b
//                         unchanged (only zero-amount shifts are routed here);
//                         codes 8-15 return 0
//     overflow out 1      signed overflow of ADD/SUB (only when the
//                         OVERFLOW_TRAP_EN macro is defined)
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
`ifdef OVERFLOW_TRAP_EN
  ,
  output logic             overflow
`endif
);

  logic [WIDTH-1:0] and_bits;
  logic [WIDTH-1:0] or_bits;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             slt_bit;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_logic_lane
      assign and_bits[gi] = a[gi] & b[gi];
      assign or_bits[gi]  = a[gi] | b[gi];
    end
  endgenerate

  // Both wrap modulo 2**WIDTH.
  assign sum     = a + b;
  assign diff    = a - b;
  assign slt_bit = ($signed(a) < $signed(b));

  always_comb begin
    result = '0;
    case (alu_ctl)
      ALU_AND:    result = and_bits;
      ALU_OR:     result = or_bits;
      ALU_ADD:    result = sum;
      ALU_PASS_A: result = a;
      ALU_SLL:    result = b;
      ALU_SRL:    result = b;
      ALU_SUB:    result = diff;
      ALU_SLT:    result = {{(WIDTH-1){1'b0}}, slt_bit};
      default:    result = '0;
    endcase
  end

`ifdef OVERFLOW_TRAP_EN
  // Signed overflow: for ADD the operands agree in sign but the sum does not;
  // for SUB the operands differ in sign and the difference takes b's sign.
  logic add_ovf;
  logic sub_ovf;
  assign add_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
  assign sub_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  assign overflow = ((alu_ctl == ALU_ADD) && add_ovf) ||
                    ((alu_ctl == ALU_SUB) && sub_ovf);
`endif

endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered MIPS execute stage.
//   Single-cycle ops (and zero-amount shifts) complete on the accept edge.
//   SLL/SRL with Shamt=n>0 run on a serial shifter, one bit per cycle; the
//   stage raises StallReq for the n SHIFT cycles so upstream holds the next
//   instruction. Flush squashes any accept or in-progress shift.
//   Optional macro OVERFLOW_TRAP_EN adds the Overflow output; on signed
//   ADD/SUB overflow RegWriteOut is suppressed.
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     InValid, ALUCtl, A, B,     ID/EX instruction, operands, shift amount
//     Shamt
//     RegWriteIn, WriteRegIn     write-back control carried from ID/EX
//     Flush                      synchronous squash
//     OutValid, Result, Zero     registered result and flags
//     RegWriteOut, WriteRegOut   registered write-back control
//     StallReq                   high while a serial shift is running
//     Overflow                   (OVERFLOW_TRAP_EN only) signed overflow
//   SHAMT_W must satisfy 2**SHAMT_W >= WIDTH.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               InValid,
  input  logic [3:0]         ALUCtl,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [SHAMT_W-1:0] Shamt,
  input  logic               RegWriteIn,
  input  logic [4:0]         WriteRegIn,
  input  logic               Flush,
  output logic               OutValid,
  output logic [WIDTH-1:0]   Result,
  output logic               Zero,
  output logic               RegWriteOut,
  output logic [4:0]         WriteRegOut,
  output logic               StallReq
`ifdef OVERFLOW_TRAP_EN
  ,
  output logic               Overflow
`endif
);

  state_t             state_reg;
  logic [WIDTH-1:0]   shift_reg;
  logic [SHAMT_W-1:0] count_reg;
  logic               dir_left_reg;   // 1: SLL, 0: SRL
  logic               rw_hold_reg;
  logic [4:0]         wr_hold_reg;

  logic               out_valid_reg;
  logic [WIDTH-1:0]   result_reg;
  logic               zero_reg;
  logic               reg_write_reg;
  logic [4:0]         write_reg_reg;
  logic               overflow_reg;

  logic [WIDTH-1:0]   comb_result;
  logic               comb_ovf;
  logic [WIDTH-1:0]   shifted_next;
  logic               is_shift;

  alu_comb #(
    .WIDTH (WIDTH)
  ) u_alu_comb (
    .alu_ctl  (ALUCtl),
    .a        (A),
    .b        (B),
    .result   (comb_result)
`ifdef OVERFLOW_TRAP_EN
    ,
    .overflow (comb_ovf)
`endif
  );

`ifndef OVERFLOW_TRAP_EN
  assign comb_ovf = 1'b0;
`endif

  assign is_shift     = (ALUCtl == ALU_SLL) || (ALUCtl == ALU_SRL);
  assign shifted_next = dir_left_reg ? (shift_reg << 1) : (shift_reg >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      shift_reg     <= '0;
      count_reg     <= '0;
      dir_left_reg  <= 1'b0;
      rw_hold_reg   <= 1'b0;
      wr_hold_reg   <= '0;
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      zero_reg      <= 1'b0;
      reg_write_reg <= 1'b0;
      write_reg_reg <= '0;
      overflow_reg  <= 1'b0;
    end else if (Flush) begin
      // Squash wins over accept and over an in-progress shift.
      state_reg     <= S_IDLE;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
      reg_write_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (InValid) begin
            if (is_shift && (Shamt != '0)) begin
              shift_reg     <= B;
              dir_left_reg  <= (ALUCtl == ALU_SLL);
              rw_hold_reg   <= RegWriteIn;
              wr_hold_reg   <= WriteRegIn;
              count_reg     <= Shamt;
              out_valid_reg <= 1'b0;
              state_reg     <= S_SHIFT;
            end else begin
              result_reg    <= comb_result;
              zero_reg      <= (comb_result == '0);
              // Overflowing ADD/SUB must not reach the register file.
              reg_write_reg <= RegWriteIn & ~comb_ovf;
              write_reg_reg <= WriteRegIn;
              overflow_reg  <= comb_ovf;
              out_valid_reg <= 1'b1;
            end
          end else begin
            out_valid_reg <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (count_reg == SHAMT_W'(1)) begin
            // Final bit: publish directly from the shifter's next value.
            result_reg    <= shifted_next;
            zero_reg      <= (shifted_next == '0);
            reg_write_reg <= rw_hold_reg;
            write_reg_reg <= wr_hold_reg;
            overflow_reg  <= 1'b0;
            out_valid_reg <= 1'b1;
            count_reg     <= '0;
            state_reg     <= S_IDLE;
          end else begin
            shift_reg     <= shifted_next;
            count_reg     <= count_reg - SHAMT_W'(1);
            out_valid_reg <= 1'b0;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Decoded from state only: no combinational path from the inputs.
  assign StallReq    = (state_reg == S_SHIFT);
  assign OutValid    = out_valid_reg;
  assign Result      = result_reg;
  assign Zero        = zero_reg;
  assign RegWriteOut = reg_write_reg;
  assign WriteRegOut = write_reg_reg;

`ifdef OVERFLOW_TRAP_EN
  assign Overflow = overflow_reg;
`else
  // Never set without the trap feature; kept so the reset/flush logic is
  // identical in both builds.
  logic unused_ovf;
  assign unused_ovf = overflow_reg;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed testbench for alu_exec_stage with hand-computed expected values.
// Define OVERFLOW_TRAP_EN to also exercise the Overflow output.
module tb_alu_exec_stage;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  logic               clk;
  logic               rst_n;
  logic               InValid;
  logic [3:0]         ALUCtl;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [SHAMT_W-1:0] Shamt;
  logic               RegWriteIn;
  logic [4:0]         WriteRegIn;
  logic               Flush;
  logic               OutValid;
  logic [WIDTH-1:0]   Result;
  logic               Zero;
  logic               RegWriteOut;
  logic [4:0]         WriteRegOut;
  logic               StallReq;
`ifdef OVERFLOW_TRAP_EN
  logic               Overflow;
`endif

  int checks   = 0;
  int failures = 0;

  alu_exec_stage #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .InValid     (InValid),
    .ALUCtl      (ALUCtl),
    .A           (A),
    .B           (B),
    .Shamt       (Shamt),
    .RegWriteIn  (RegWriteIn),
    .WriteRegIn  (WriteRegIn),
    .Flush       (Flush),
    .OutValid    (OutValid),
    .Result      (Result),
    .Zero        (Zero),
    .RegWriteOut (RegWriteOut),
    .WriteRegOut (WriteRegOut),
    .StallReq    (StallReq)
`ifdef OVERFLOW_TRAP_EN
    ,
    .Overflow    (Overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] ctl, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh, input logic rw,
                       input logic [4:0] wr);
    InValid    = v;
    ALUCtl     = ctl;
    A          = a;
    B          = b;
    Shamt      = sh;
    RegWriteIn = rw;
    WriteRegIn = wr;
  endtask

  // Advance one edge and sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One single-cycle op: drive, clock, check result/zero/valid.
  task automatic op1(input string tag, input logic [3:0] ctl, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp_res);
    drive(1'b1, ctl, a, b, 5'd0, 1'b1, 5'd1);
    step();
    check({tag, ".res"}, 64'(Result), 64'(exp_res));
    check({tag, ".zero"}, 64'(Zero), 64'(exp_res == 32'd0));
    check({tag, ".valid"}, 64'(OutValid), 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    Flush = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid", 64'(OutValid), 64'd0);
    check("rst.res", 64'(Result), 64'd0);
    check("rst.stall", 64'(StallReq), 64'd0);
    rst_n = 1'b1;

    // ADD with write-back control.
    drive(1'b1, 4'd2, 32'd5, 32'd7, 5'd0, 1'b1, 5'd9);
    step();
    check("add.res", 64'(Result), 64'd12);
    check("add.zero", 64'(Zero), 64'd0);
    check("add.valid", 64'(OutValid), 64'd1);
    check("add.rw", 64'(RegWriteOut), 64'd1);
    check("add.wr", 64'(WriteRegOut), 64'd9);
    check("add.stall", 64'(StallReq), 64'd0);
`ifdef OVERFLOW_TRAP_EN
    check("add.ovf", 64'(Overflow), 64'd0);
`endif

    // Back-to-back single-cycle ops, one per cycle.
    op1("sub", 4'd6, 32'd9, 32'd9, 32'd0);
    op1("slt_neg", 4'd7, 32'hFFFF_FFFF, 32'd1, 32'd1);
    op1("slt_pos", 4'd7, 32'd1, 32'hFFFF_FFFF, 32'd0);
    op1("and", 4'd0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
    op1("or", 4'd1, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01);
    op1("pass_a", 4'd3, 32'hDEAD_BEEF, 32'd1, 32'hDEAD_BEEF);
    op1("sub_wrap", 4'd6, 32'd0, 32'd1, 32'hFFFF_FFFF);
    op1("ctl12", 4'd12, 32'd5, 32'd7, 32'd0);

    // Idle cycle: OutValid drops, Result holds.
    drive(1'b0, 4'd2, 32'd1, 32'd1, 5'd0, 1'b1, 5'd4);
    step();
    check("idle.valid", 64'(OutValid), 64'd0);
    check("idle.res", 64'(Result), 64'd0);

    // SLL 1<<4 followed by ADD 2+3 held upstream.
    drive(1'b1, 4'd4, 32'd0, 32'd1, 5'd4, 1'b1, 5'd5);
    step();
    check("sll.acc.stall", 64'(StallReq), 64'd1);
    check("sll.acc.valid", 64'(OutValid), 64'd0);
    drive(1'b1, 4'd2, 32'd2, 32'd3, 5'd0, 1'b1, 5'd6);
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("sll.s%0d.stall", i), 64'(StallReq), 64'd1);
      check($sformatf("sll.s%0d.valid", i), 64'(OutValid), 64'd0);
    end
    step();
    check("sll.res", 64'(Result), 64'h10);
    check("sll.valid", 64'(OutValid), 64'd1);
    check("sll.stall", 64'(StallReq), 64'd0);
    check("sll.wr", 64'(WriteRegOut), 64'd5);
    step();
    check("held_add.res", 64'(Result), 64'd5);
    check("held_add.wr", 64'(WriteRegOut), 64'd6);
    check("held_add.valid", 64'(OutValid), 64'd1);

    // SRL 0x80000000 >> 31: result 32 edges after accept.
    drive(1'b1, 4'd5, 32'd0, 32'h8000_0000, 5'd31, 1'b1, 5'd8);
    step();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 5'd0);
    for (int i = 1; i <= 30; i++) begin
      step();
      if (OutValid !== 1'b0 || StallReq !== 1'b1)
        check($sformatf("srl31.s%0d.busy", i), {62'd0, OutValid, StallReq}, 64'd1);
    end
    check("srl31.busy", {62'd0, OutValid, StallReq}, 64'd1);
    step();
    check("srl31.res", 64'(Result), 64'd1);
    check("srl31.valid", 64'(OutValid), 64'd1);
    check("srl31.stall", 64'(StallReq), 64'd0);

    // Zero-amount SRL: single-cycle, no stall.
    drive(1'b1, 4'd5, 32'd0, 32'hABCD_0000, 5'd0, 1'b1, 5'd3);
    step();
    check("srl0.res", 64'(Result), 64'hABCD_0000);
    check("srl0.valid", 64'(OutValid), 64'd1);
    check("srl0.stall", 64'(StallReq), 64'd0);

    // Flush during SHIFT with count=2.
    drive(1'b1, 4'd4, 32'd0, 32'd3, 5'd4, 1'b1, 5'd7);
    step();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 5'd0);
    step();
    step();
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    check("flush.valid", 64'(OutValid), 64'd0);
    check("flush.rw", 64'(RegWriteOut), 64'd0);
    check("flush.stall", 64'(StallReq), 64'd0);
    drive(1'b1, 4'd2, 32'd10, 32'd20, 5'd0, 1'b1, 5'd2);
    step();
    check("post_flush.res", 64'(Result), 64'd30);
    check("post_flush.valid", 64'(OutValid), 64'd1);
    check("post_flush.rw", 64'(RegWriteOut), 64'd1);

    // Flush in the accept cycle drops the instruction.
    drive(1'b1, 4'd2, 32'd1, 32'd1, 5'd0, 1'b1, 5'd2);
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    check("flush_acc.valid", 64'(OutValid), 64'd0);
    check("flush_acc.res", 64'(Result), 64'd30);

    // Asynchronous reset in the middle of a shift.
    drive(1'b1, 4'd4, 32'd0, 32'd1, 5'd8, 1'b1, 5'd4);
    step();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 5'd0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.stall", 64'(StallReq), 64'd0);
    check("arst.res", 64'(Result), 64'd0);
    check("arst.wr", 64'(WriteRegOut), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 4'd2, 32'd1, 32'd2, 5'd0, 1'b1, 5'd1);
    step();
    check("post_arst.res", 64'(Result), 64'd3);
    check("post_arst.stall", 64'(StallReq), 64'd0);

`ifdef OVERFLOW_TRAP_EN
    drive(1'b1, 4'd2, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b1, 5'd1);
    step();
    check("ovf_add.flag", 64'(Overflow), 64'd1);
    check("ovf_add.rw", 64'(RegWriteOut), 64'd0);
    check("ovf_add.res", 64'(Result), 64'h8000_0000);
    drive(1'b1, 4'd6, 32'h8000_0000, 32'd1, 5'd0, 1'b1, 5'd1);
    step();
    check("ovf_sub.flag", 64'(Overflow), 64'd1);
    check("ovf_sub.res", 64'(Result), 64'h7FFF_FFFF);
    drive(1'b1, 4'd2, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b1, 5'd1);
    step();
    check("no_ovf.flag", 64'(Overflow), 64'd0);
    check("no_ovf.rw", 64'(RegWriteOut), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
Registered execute stage of the MIPS pipeline. It sits directly downstream of the ALU control decoder and consumes its 4-bit ALU operation code together with the ID/EX operands. It produces the EX/MEM-side result, zero flag and write-back control. Shifts run iteratively, one bit per cycle, and the stage stalls upstream while a shift is in progress.

Parameters:
WIDTH, 32, datapath width of operands and result
SHAMT_W, 5, width of the shift-amount field (must satisfy 2**SHAMT_W >= WIDTH)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
InValid  in  1  ID/EX holds a valid instruction this cycle
ALUCtl  in  4  operation code from the ALU control decoder
A  in  WIDTH  operand rs
B  in  WIDTH  operand rt or sign-extended immediate
Shamt  in  SHAMT_W  shift amount
RegWriteIn  in  1  register write-enable carried from ID/EX
WriteRegIn  in  5  destination register number
Flush  in  1  synchronous squash from the hazard/branch unit
OutValid  out  1  Result and associated fields are valid
Result  out  WIDTH  registered ALU result
Zero  out  1  registered (Result == 0)
RegWriteOut  out  1  registered write-enable
WriteRegOut  out  5  registered destination register
StallReq  out  1  upstream must hold ID/EX contents this cycle

Behaviour:
- Reset (asynchronous, rst_n low) clears all outputs to 0, sets the FSM to IDLE and clears the internal shift register and counter. Reset takes effect immediately, including in the middle of a shift.
- ALUCtl encoding:
  - 0 AND, 1 OR, 2 ADD, 3 PASS_A (jr), 4 SLL, 5 SRL, 6 SUB, 7 SLT.
  - Codes 8–15 produce Result 0.
- Arithmetic:
  - ADD and SUB wrap modulo 2**WIDTH.
  - SLT is a signed compare; Result is 1 or 0, zero-extended.
  - SLL and SRL shift B by Shamt; SRL is a logical shift.
- FSM states: IDLE and SHIFT.
- IDLE, InValid=1, ALUCtl not SLL/SRL, or SLL/SRL with Shamt==0:
  - Next edge registers Result, Zero, RegWriteOut=RegWriteIn, WriteRegOut=WriteRegIn and OutValid=1.
  - Latency is 1 cycle.
- IDLE, InValid=1, SLL/SRL with Shamt=n>0:
  - Next edge latches B, the direction, RegWriteIn and WriteRegIn.
  - Sets count=n, sets OutValid=0 and moves to SHIFT.
- IDLE, InValid=0: next edge sets OutValid=0; other outputs hold their values.
- SHIFT:
  - Each edge shifts the latched value by 1 and decrements count.
  - On the edge where count==1, the shifted value is written to Result and Zero, OutValid=1, and the FSM returns to IDLE.
  - OutValid is 0 on all other SHIFT edges.
- StallReq = (state==SHIFT). It is decoded from state only, with no combinational path from inputs.
  - The shift instruction is consumed at its accept edge.
  - The following instruction is held by upstream for the n SHIFT cycles and accepted in the first IDLE cycle.
- InValid and all operand inputs are ignored while in SHIFT.
- A shift of n>0 produces its result n+1 edges after the accept cycle begins.
- Flush has highest priority over all other activity. The next edge sets OutValid=0 and RegWriteOut=0, moves the FSM to IDLE and abandons any in-progress shift.
- Flush in the same cycle as an accept: the instruction is dropped.
- Back-to-back non-shift instructions sustain 1 instruction per cycle.

Optional Feature:
OVERFLOW_TRAP_EN
- Defined:
  - Adds an output Overflow (1 bit, reset 0), registered alongside Result.
  - Overflow is set on signed overflow of ADD or SUB.
  - On overflow, RegWriteOut is forced to 0 and Result still holds the wrapped sum.
  - Flush clears Overflow.
- Undefined: the Overflow port does not exist and ADD/SUB wrap silently.

Decomposition:
- Package alu_pkg holds:
  - localparams for the ALUCtl codes (ALU_AND … ALU_SLT), shared with the ALU control decoder;
  - the FSM state encoding (S_IDLE, S_SHIFT).
- Sub-module alu_comb: purely combinational datapath for the single-cycle ops (AND, OR, ADD, SUB, SLT, PASS_A, zero-amount shifts), plus the overflow term.
- alu_exec_stage owns the FSM, the serial shifter, the counter and the output registers.

Test Plan:
- ADD A=5 B=7, RegWriteIn=1, WriteRegIn=9 -> after 1 edge: Result=12, Zero=0, OutValid=1, RegWriteOut=1, WriteRegOut=9.
- SUB A=9 B=9 -> Result=0, Zero=1. SLT A=0xFFFFFFFF B=1 -> Result=1. ALUCtl=12 -> Result=0.
- SLL B=1 Shamt=4, then ADD 2+3 held by upstream -> StallReq high for exactly 4 cycles, OutValid=0 during them, Result=0x10 on the 5th edge, then Result=5 one edge later.
- SRL B=0x80000000 Shamt=31 -> Result=1 after 32 edges; Shamt=0 -> Result=B with 1-cycle latency and no stall.
- Flush during SHIFT with count=2 -> OutValid stays 0, RegWriteOut=0, StallReq low the next cycle, next ADD executes normally.
- rst_n low mid-shift -> all outputs 0 without waiting for a clock edge, FSM IDLE. With OVERFLOW_TRAP_EN: ADD 0x7FFFFFFF+1 -> Overflow=1, RegWriteOut=0, Result=0x80000000.
